// File: rtl/regfile_pkg.sv
// regfile_pkg: shared definitions for the picoMIPS register-file port arbiter.
//   - DATA_BUS_SIZE fallback width (8) when the build does not define it.
//   - Register-file special addresses: zero, input port, output port.
//   - rf_req_t:  one requester's access bundle at default widths.
//   - owner_t:   which requester owns the port in a cycle.
//   - is_read_only(): true for the addresses a write must never reach.
`ifndef DATA_BUS_SIZE
`define DATA_BUS_SIZE 8
`endif

package regfile_pkg;

  localparam int DATA_W    = `DATA_BUS_SIZE;
  localparam int RF_ADDR_W = 3;

  localparam int REG_ZERO    = 0;  // hard-wired zero register
  localparam int REG_INPORT  = 1;  // driven by the input port, not writable
  localparam int REG_OUTPORT = 2;  // output port register, writable

  typedef struct packed {
    logic                 req;
    logic                 we;
    logic [RF_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]    wdata;
  } rf_req_t;

  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_t;

  function automatic logic is_read_only(input int unsigned addr);
    return (addr == REG_ZERO) || (addr == REG_INPORT);
  endfunction

endpackage

// File: rtl/regfile_port_arbiter_if.sv
// regfile_port_arbiter_if: bundle of the two requester ports, the register-file
// drive and the violation reporting of the arbiter.
//
// Handshake: a requester raises req with we/addr/wdata (B also lock) and
// holds them stable until gnt is seen high in the same cycle; gnt is
// combinational and the access is consumed in the cycle gnt is high. For a
// granted read, rvalid is high for exactly one cycle, the cycle after the
// grant, with rdata; rdata keeps its value until the next read completes.
//
// Modports:
//   slave  - the arbiter (consumes requests and rf_rs_data, drives the rest)
//   master - requesters plus register file (the opposite directions)
interface regfile_port_arbiter_if #(
  parameter int N      = `DATA_BUS_SIZE,
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 8
);
  logic              a_req, a_we, a_gnt, a_rvalid;
  logic [ADDR_W-1:0] a_addr;
  logic [N-1:0]      a_wdata, a_rdata;
  logic              b_req, b_we, b_gnt, b_rvalid, b_lock;
  logic [ADDR_W-1:0] b_addr;
  logic [N-1:0]      b_wdata, b_rdata;
  logic              rf_w;
  logic [ADDR_W-1:0] rf_r_dest, rf_r_source;
  logic [N-1:0]      rf_write_data, rf_rs_data;
  logic              ro_violation;
  logic [CNT_W-1:0]  viol_count;

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata, b_lock,
    input  rf_rs_data,
    output a_gnt, a_rvalid, a_rdata,
    output b_gnt, b_rvalid, b_rdata,
    output rf_w, rf_r_dest, rf_r_source, rf_write_data,
    output ro_violation, viol_count
  );

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata, b_lock,
    output rf_rs_data,
    input  a_gnt, a_rvalid, a_rdata,
    input  b_gnt, b_rvalid, b_rdata,
    input  rf_w, rf_r_dest, rf_r_source, rf_write_data,
    input  ro_violation, viol_count
  );
endinterface

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with a lock override for requester B
// and a watchdog that bounds how long a lock may starve requester A.
//   clk, n_reset : clock, asynchronous active-low reset
//   req[1:0]     : requests, bit 0 = A, bit 1 = B
//   lock         : B asks to keep the port (only meaningful with req[1])
//   gnt[1:0]     : one-hot grant, same cycle (combinational)
//   owner        : requester granted this cycle (OWNER_A when idle)
module rr_arb2
  import regfile_pkg::*;
#(
  parameter int LOCK_MAX = 16
) (
  input  logic       clk,
  input  logic       n_reset,
  input  logic [1:0] req,
  input  logic       lock,
  output logic [1:0] gnt,
  output owner_t     owner
);

  localparam int CW = $clog2(LOCK_MAX + 1);

  owner_t          last_q;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            lock_win;

  always_comb begin
    gnt        = 2'b00;
    lock_cnt_d = '0;
    // Once the counter reaches LOCK_MAX the lock stops overriding; with A
    // waiting, plain round-robin then hands A the slot because B won last.
    lock_win   = req[1] & lock & (lock_cnt_q < CW'(LOCK_MAX));
    if (lock_win)        gnt = 2'b10;
    else if (&req)       gnt = (last_q == OWNER_B) ? 2'b01 : 2'b10;
    else if (req[0])     gnt = 2'b01;
    else if (req[1])     gnt = 2'b10;
    owner = gnt[1] ? OWNER_B : OWNER_A;
    // Locked B grants count up and hold at LOCK_MAX (B alone keeps going);
    // anything else -- an A grant, an unlocked cycle, an idle cycle -- clears.
    if (gnt[1] && lock) begin
      if (lock_cnt_q < CW'(LOCK_MAX)) lock_cnt_d = lock_cnt_q + 1'b1;
      else                            lock_cnt_d = lock_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      last_q     <= OWNER_B;  // A wins the first contention after reset
      lock_cnt_q <= '0;
    end else begin
      lock_cnt_q <= lock_cnt_d;
      if (|gnt) last_q <= owner;
    end
  end

endmodule

// File: rtl/regfile_port_arbiter.sv
// regfile_port_arbiter: shares the single picoMIPS register-file access path
// between the core datapath (A) and the boot loader / debug port (B).
//   clk, n_reset : clock, asynchronous active-low reset
//   bus (slave)  : requester ports, register-file drive, read data return,
//                  read-only violation pulse and saturating violation count
// Parameters: N data width, ADDR_W register address width, LOCK_MAX bound on
// consecutive locked B grants, CNT_W violation counter width.
module regfile_port_arbiter
  import regfile_pkg::*;
#(
  parameter int N        = `DATA_BUS_SIZE,
  parameter int ADDR_W   = 3,
  parameter int LOCK_MAX = 16,
  parameter int CNT_W    = 8
) (
  input  logic                  clk,
  input  logic                  n_reset,
  regfile_port_arbiter_if.slave bus
);

  logic [1:0]        gnt;
  owner_t            owner;
  logic              any_gnt;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [N-1:0]      win_wdata;
  logic              ro_hit;

  rr_arb2 #(.LOCK_MAX(LOCK_MAX)) u_arb (
    .clk     (clk),
    .n_reset (n_reset),
    .req     ({bus.b_req, bus.a_req}),
    .lock    (bus.b_lock),
    .gnt     (gnt),
    .owner   (owner)
  );

  assign bus.a_gnt = gnt[0];
  assign bus.b_gnt = gnt[1];

  always_comb begin
    any_gnt   = |gnt;
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (any_gnt) begin
      win_we    = (owner == OWNER_B) ? bus.b_we    : bus.a_we;
      win_addr  = (owner == OWNER_B) ? bus.b_addr  : bus.a_addr;
      win_wdata = (owner == OWNER_B) ? bus.b_wdata : bus.a_wdata;
    end
    // A write to zero/inport is still granted and consumed, but suppressed.
    ro_hit = any_gnt & win_we & is_read_only(32'(win_addr));
  end

  assign bus.rf_w          = any_gnt & win_we & ~ro_hit;
  assign bus.rf_r_dest     = win_addr;
  assign bus.rf_r_source   = win_addr;
  assign bus.rf_write_data = win_wdata;

  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      bus.a_rvalid     <= 1'b0;
      bus.b_rvalid     <= 1'b0;
      bus.a_rdata      <= '0;
      bus.b_rdata      <= '0;
      bus.ro_violation <= 1'b0;
      bus.viol_count   <= '0;
    end else begin
      bus.a_rvalid     <= gnt[0] & ~bus.a_we;
      bus.b_rvalid     <= gnt[1] & ~bus.b_we;
      if (gnt[0] && !bus.a_we) bus.a_rdata <= bus.rf_rs_data;
      if (gnt[1] && !bus.b_we) bus.b_rdata <= bus.rf_rs_data;
      bus.ro_violation <= ro_hit;
      if (ro_hit && (bus.viol_count != {CNT_W{1'b1}}))
        bus.viol_count <= bus.viol_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_regfile_port_arbiter.sv
// tb_regfile_port_arbiter: directed bench for regfile_port_arbiter with
// LOCK_MAX=4 and CNT_W=2, a small register-file model behind the port, and a
// scoreboard of expected read data / violation counts checked by a monitor.
module tb_regfile_port_arbiter;
  import regfile_pkg::*;

  logic clk;
  logic n_reset;
  int   n_checks;
  int   n_pass;
  int   cyc;
  int   exp_vc;

  logic [23:0] exp_a_q[$];   // {due cycle[15:0], rdata[7:0]}
  logic [23:0] exp_b_q[$];
  logic [17:0] exp_v_q[$];   // {due cycle[15:0], viol_count[1:0]}
  logic [7:0]  rf_mem [8];

  regfile_port_arbiter_if #(.N(8), .ADDR_W(3), .CNT_W(2)) bus ();

  regfile_port_arbiter #(.N(8), .ADDR_W(3), .LOCK_MAX(4), .CNT_W(2)) dut (
    .clk     (clk),
    .n_reset (n_reset),
    .bus     (bus.slave)
  );

  // ---------------- clock / reset / register-file model ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (!n_reset) begin
      for (int i = 0; i < 8; i++) rf_mem[i] <= 8'(i * 17);
    end else if (bus.rf_w) begin
      rf_mem[bus.rf_r_dest] <= bus.rf_write_data;
    end
  end

  assign bus.rf_rs_data = rf_mem[bus.rf_r_source];

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish in time");
    $fatal(1, "timeout");
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  function automatic rf_req_t rq(input logic we, input logic [2:0] ad, input logic [7:0] wd);
    return {1'b1, we, ad, wd};
  endfunction

  // ---------------- driver ----------------
  // Called just after a rising edge; applies one cycle of requests, checks
  // the combinational grant/drive at the falling edge and queues the
  // responses that must appear one cycle later.
  task automatic drive(input string nm, input rf_req_t a, input rf_req_t b,
                       input logic bl, input logic [1:0] eg, input logic ew,
                       input logic [7:0] erd);
    rf_req_t w;
    bus.a_req = a.req; bus.a_we = a.we; bus.a_addr = a.addr; bus.a_wdata = a.wdata;
    bus.b_req = b.req; bus.b_we = b.we; bus.b_addr = b.addr; bus.b_wdata = b.wdata;
    bus.b_lock = bl;
    @(negedge clk);
    w = eg[1] ? b : (eg[0] ? a : '0);
    chk({nm, "_gnt"},   {bus.b_gnt, bus.a_gnt}, eg);
    chk({nm, "_rf_w"},  bus.rf_w, ew);
    chk({nm, "_src"},   bus.rf_r_source, w.addr);
    chk({nm, "_dest"},  bus.rf_r_dest, w.addr);
    chk({nm, "_wdata"}, bus.rf_write_data, w.wdata);
    if (eg != 2'b00 && !w.we) begin
      if (eg[1]) exp_b_q.push_back({16'(cyc + 1), erd});
      else       exp_a_q.push_back({16'(cyc + 1), erd});
    end
    if (eg != 2'b00 && w.we && !ew) begin
      exp_vc = (exp_vc == 3) ? 3 : exp_vc + 1;
      exp_v_q.push_back({16'(cyc + 1), 2'(exp_vc)});
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (n_reset) begin
      if (bus.a_rvalid) begin
        if (exp_a_q.size() == 0) chk("a_rvalid_unexpected", 1, 0);
        else begin
          logic [23:0] e;
          e = exp_a_q.pop_front();
          chk("a_rdata", bus.a_rdata, e[7:0]);
          chk("a_rvalid_cycle", 16'(cyc), e[23:8]);
        end
      end else if (exp_a_q.size() != 0 && exp_a_q[0][23:8] <= 16'(cyc)) begin
        void'(exp_a_q.pop_front());
        chk("a_rvalid_missing", 0, 1);
      end
      if (bus.b_rvalid) begin
        if (exp_b_q.size() == 0) chk("b_rvalid_unexpected", 1, 0);
        else begin
          logic [23:0] e;
          e = exp_b_q.pop_front();
          chk("b_rdata", bus.b_rdata, e[7:0]);
          chk("b_rvalid_cycle", 16'(cyc), e[23:8]);
        end
      end else if (exp_b_q.size() != 0 && exp_b_q[0][23:8] <= 16'(cyc)) begin
        void'(exp_b_q.pop_front());
        chk("b_rvalid_missing", 0, 1);
      end
      if (bus.ro_violation) begin
        if (exp_v_q.size() == 0) chk("ro_violation_unexpected", 1, 0);
        else begin
          logic [17:0] e;
          e = exp_v_q.pop_front();
          chk("viol_count", bus.viol_count, e[1:0]);
          chk("ro_violation_cycle", 16'(cyc), e[17:2]);
        end
      end else if (exp_v_q.size() != 0 && exp_v_q[0][17:2] <= 16'(cyc)) begin
        void'(exp_v_q.pop_front());
        chk("ro_violation_missing", 0, 1);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rf_req_t idle;
    idle = '0;
    n_checks = 0; n_pass = 0; cyc = 0; exp_vc = 0;
    n_reset = 1'b0;
    bus.a_req = 0; bus.a_we = 0; bus.a_addr = 0; bus.a_wdata = 0;
    bus.b_req = 0; bus.b_we = 0; bus.b_addr = 0; bus.b_wdata = 0; bus.b_lock = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_a_rvalid", bus.a_rvalid, 0);
    chk("rst_b_rvalid", bus.b_rvalid, 0);
    chk("rst_a_rdata", bus.a_rdata, 0);
    chk("rst_b_rdata", bus.b_rdata, 0);
    chk("rst_ro_violation", bus.ro_violation, 0);
    chk("rst_viol_count", bus.viol_count, 0);
    chk("rst_gnt_idle", {bus.b_gnt, bus.a_gnt}, 2'b00);
    n_reset = 1'b1;
    @(posedge clk); #1;

    // Post-reset contention: A, B, A.
    drive("cont0", rq(0, 3, 0), rq(0, 4, 0), 0, 2'b01, 0, 8'h33);
    drive("cont1", rq(0, 3, 0), rq(0, 4, 0), 0, 2'b10, 0, 8'h44);
    drive("cont2", rq(0, 3, 0), rq(0, 4, 0), 0, 2'b01, 0, 8'h33);

    // Write path then read-back.
    drive("bwr5",  idle, rq(1, 5, 8'h5A), 0, 2'b10, 1, 8'h00);
    drive("ard5",  rq(0, 5, 0), idle, 0, 2'b01, 0, 8'h5A);

    // Read-only protection; outport is writable.
    drive("awr0",  rq(1, 3'(REG_ZERO), 8'hFF), idle, 0, 2'b01, 0, 8'h00);
    drive("awr1",  rq(1, 3'(REG_INPORT), 8'hFF), idle, 0, 2'b01, 0, 8'h00);
    drive("awr2",  rq(1, 3'(REG_OUTPORT), 8'h2C), idle, 0, 2'b01, 1, 8'h00);
    drive("ard2",  rq(0, 3'(REG_OUTPORT), 0), idle, 0, 2'b01, 0, 8'h2C);

    // Lock watchdog (LOCK_MAX=4): B,B,B,B,A repeating.
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++)
        drive("lockB", rq(0, 6, 0), rq(0, 4, 0), 1, 2'b10, 0, 8'h44);
      drive("lockA", rq(0, 6, 0), rq(0, 4, 0), 1, 2'b01, 0, 8'h66);
    end

    // Locked B alone past LOCK_MAX keeps going; A then wins immediately.
    for (int k = 0; k < 6; k++)
      drive("lockBsolo", idle, rq(0, 7, 0), 1, 2'b10, 0, 8'h77);
    drive("lockHeldA", rq(0, 3, 0), rq(0, 4, 0), 1, 2'b01, 0, 8'h33);
    drive("lockAfterA", rq(0, 3, 0), rq(0, 4, 0), 1, 2'b10, 0, 8'h44);

    // Counter saturation at 3 (total five read-only writes).
    drive("bwr1a", idle, rq(1, 1, 8'h11), 0, 2'b10, 0, 8'h00);
    drive("bwr0",  idle, rq(1, 0, 8'h22), 0, 2'b10, 0, 8'h00);
    drive("bwr1b", idle, rq(1, 1, 8'h33), 0, 2'b10, 0, 8'h00);

    // No request: drives are zero even with stale fields on A.
    drive("idle",  {1'b0, 1'b1, 3'd5, 8'hAA}, idle, 0, 2'b00, 0, 8'h00);
    drive("idle2", idle, idle, 0, 2'b00, 0, 8'h00);

    // Reset mid-read: pending rvalid and rdata are discarded at once.
    bus.a_req = 1; bus.a_we = 0; bus.a_addr = 3'd7; bus.a_wdata = 0;
    @(negedge clk);
    chk("mid_gnt", {bus.b_gnt, bus.a_gnt}, 2'b01);
    @(posedge clk); #1;
    chk("mid_rvalid_pre", bus.a_rvalid, 1);
    chk("mid_rdata_pre", bus.a_rdata, 8'h77);
    n_reset = 1'b0;
    bus.a_req = 0;
    #1;
    chk("mid_rvalid_rst", bus.a_rvalid, 0);
    chk("mid_rdata_rst", bus.a_rdata, 0);
    chk("mid_viol_rst", bus.viol_count, 0);
    exp_vc = 0;
    @(posedge clk); #1;
    n_reset = 1'b1;
    @(posedge clk); #1;
    drive("post_rst0", rq(0, 3, 0), rq(0, 4, 0), 0, 2'b01, 0, 8'h33);
    drive("post_rst1", rq(0, 3, 0), rq(0, 4, 0), 0, 2'b10, 0, 8'h44);
    drive("drain0", idle, idle, 0, 2'b00, 0, 8'h00);
    drive("drain1", idle, idle, 0, 2'b00, 0, 8'h00);

    chk("a_queue_empty", exp_a_q.size(), 0);
    chk("b_queue_empty", exp_b_q.size(), 0);
    chk("v_queue_empty", exp_v_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
